// File: rtl/adc128s_pkg.sv
// Shared constants and types for the adc128s_model SPI ADC bench model.
package adc128s_pkg;

   localparam int FRAME_BITS = 16;
   localparam int ADDR_MSB   = 13;
   localparam int ADDR_LSB   = 11;

   typedef logic [11:0] adc_val_t;

   typedef enum logic [2:0] {
      B1  = 3'd0,
      LP  = 3'd1,
      B3  = 3'd2,
      HP  = 3'd3,
      B2  = 3'd4,
      VOL = 3'd7
   } chan_role_e;

endpackage

// File: rtl/spi_slave_shift16.sv
// 16-bit SPI slave datapath: input synchronizers, edge detection, bit counter,
// RX/TX shift registers and the frame-done pulse with its decoded address.
module spi_slave_shift16
   import adc128s_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        ss_n_i,
   input  logic        sclk_i,
   input  logic        mosi_i,
   input  logic [15:0] load_word_i,
   output logic        miso_o,
   output logic        done_o,
   output logic [2:0]  addr_o
);

   localparam logic [4:0] CNT_FULL = 5'(FRAME_BITS);
   localparam logic [4:0] CNT_LAST = 5'(FRAME_BITS - 1);

   logic [1:0]  ss_sync_q, ss_sync_d;
   logic [1:0]  sclk_sync_q, sclk_sync_d;
   logic [1:0]  mosi_sync_q, mosi_sync_d;
   logic        ss_prev_q, ss_prev_d;
   logic        sclk_prev_q, sclk_prev_d;
   logic [4:0]  bit_cnt_q, bit_cnt_d;
   logic [15:0] rx_q, rx_d;
   logic [15:0] tx_q, tx_d;
   logic        miso_q, miso_d;

   logic ss_s, sclk_s, mosi_s;
   logic ss_fall_s, ss_rise_s, sclk_rise_s, sclk_fall_s, abort_s, done_s;
   logic rx_unused_s;

   assign ss_s   = ss_sync_q[1];
   assign sclk_s = sclk_sync_q[1];
   assign mosi_s = mosi_sync_q[1];

   // SCLK edges only count while the frame select is low
   assign ss_fall_s   = ss_prev_q & ~ss_s;
   assign ss_rise_s   = ~ss_prev_q & ss_s;
   assign sclk_rise_s = ~sclk_prev_q & sclk_s & ~ss_s;
   assign sclk_fall_s = sclk_prev_q & ~sclk_s & ~ss_s;
   assign abort_s     = ss_rise_s & (bit_cnt_q != CNT_FULL);
   assign done_s      = sclk_rise_s & (bit_cnt_q == CNT_LAST);
   assign rx_unused_s = rx_q[15];

   always_comb begin
      ss_sync_d   = {ss_sync_q[0], ss_n_i};
      sclk_sync_d = {sclk_sync_q[0], sclk_i};
      mosi_sync_d = {mosi_sync_q[0], mosi_i};
      ss_prev_d   = ss_s;
      sclk_prev_d = sclk_s;
      bit_cnt_d   = bit_cnt_q;
      rx_d        = rx_q;
      tx_d        = tx_q;
      if (ss_fall_s) begin
         bit_cnt_d = 5'd0;
         rx_d      = 16'h0000;
         tx_d      = load_word_i;
      end else if (abort_s) begin
         bit_cnt_d = 5'd0;
         rx_d      = 16'h0000;
      end else if (sclk_rise_s && (bit_cnt_q != CNT_FULL)) begin
         rx_d      = {rx_q[14:0], mosi_s};
         bit_cnt_d = bit_cnt_q + 5'd1;
      end else if (sclk_fall_s && (bit_cnt_q != 5'd0)) begin
         tx_d = {tx_q[14:0], 1'b0};
      end else begin
         tx_d = tx_q;
      end
      // MISO lags the TX register by one clk and is forced low outside a frame
      if (ss_s || ss_fall_s) begin
         miso_d = 1'b0;
      end else begin
         miso_d = tx_q[15];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ss_sync_q   <= 2'b11;
         sclk_sync_q <= 2'b11;
         mosi_sync_q <= 2'b11;
         ss_prev_q   <= 1'b1;
         sclk_prev_q <= 1'b1;
         bit_cnt_q   <= 5'd0;
         rx_q        <= 16'h0000;
         tx_q        <= 16'h0000;
         miso_q      <= 1'b0;
      end else begin
         ss_sync_q   <= ss_sync_d;
         sclk_sync_q <= sclk_sync_d;
         mosi_sync_q <= mosi_sync_d;
         ss_prev_q   <= ss_prev_d;
         sclk_prev_q <= sclk_prev_d;
         bit_cnt_q   <= bit_cnt_d;
         rx_q        <= rx_d;
         tx_q        <= tx_d;
         miso_q      <= miso_d;
      end
   end

   assign miso_o = miso_q;
   assign done_o = done_s;
   assign addr_o = rx_d[ADDR_MSB:ADDR_LSB];

endmodule

// File: rtl/adc128s_model.sv
// 8-channel 12-bit SPI ADC model with one-frame result pipelining.
// Define ADC128S_MODEL_RAMP_EN to advance a channel by RAMP_STEP each time it is read.
module adc128s_model
   import adc128s_pkg::*;
#(
   parameter logic [11:0] CH_VAL_0  = 12'h000,
   parameter logic [11:0] CH_VAL_1  = 12'h800,
   parameter logic [11:0] CH_VAL_2  = 12'h000,
   parameter logic [11:0] CH_VAL_3  = 12'h000,
   parameter logic [11:0] CH_VAL_4  = 12'h000,
   parameter logic [11:0] CH_VAL_5  = 12'h000,
   parameter logic [11:0] CH_VAL_6  = 12'h000,
   parameter logic [11:0] CH_VAL_7  = 12'hFFF,
   parameter logic [11:0] RAMP_STEP = 12'h010
) (
   input  logic clk,
   input  logic rst,
   input  logic SS_n,
   input  logic SCLK,
   input  logic MOSI,
   output logic MISO
);

`ifdef ADC128S_MODEL_RAMP_EN
   localparam logic RAMP_ON = 1'b1;
`else
   localparam logic RAMP_ON = 1'b0;
`endif

   localparam adc_val_t CH_INIT [8] = '{CH_VAL_0, CH_VAL_1, CH_VAL_2, CH_VAL_3,
                                        CH_VAL_4, CH_VAL_5, CH_VAL_6, CH_VAL_7};

   adc_val_t   val_q [8];
   adc_val_t   val_d [8];
   logic [2:0] chan_ptr_q, chan_ptr_d;

   logic        done_s;
   logic [2:0]  addr_s;
   logic [15:0] load_word_s;

   assign load_word_s = {4'b0000, val_q[chan_ptr_q]};

   spi_slave_shift16 u_spi (
      .clk         (clk),
      .rst         (rst),
      .ss_n_i      (SS_n),
      .sclk_i      (SCLK),
      .mosi_i      (MOSI),
      .load_word_i (load_word_s),
      .miso_o      (MISO),
      .done_o      (done_s),
      .addr_o      (addr_s)
   );

   // The channel just returned is the one that ramps, before the pointer moves on
   always_comb begin
      val_d      = val_q;
      chan_ptr_d = chan_ptr_q;
      if (done_s) begin
         chan_ptr_d = addr_s;
         if (RAMP_ON) begin
            val_d[chan_ptr_q] = val_q[chan_ptr_q] + RAMP_STEP;
         end else begin
            val_d[chan_ptr_q] = val_q[chan_ptr_q];
         end
      end else begin
         chan_ptr_d = chan_ptr_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         val_q      <= CH_INIT;
         chan_ptr_q <= B1;
      end else begin
         val_q      <= val_d;
         chan_ptr_q <= chan_ptr_d;
      end
   end

endmodule

// File: tb/tb_adc128s_model.sv
// Directed bench for adc128s_model: mode-3 SPI master with hand-computed results.
module tb_adc128s_model;

`ifdef ADC128S_MODEL_RAMP_EN
   localparam bit RAMP = 1'b1;
`else
   localparam bit RAMP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst, SS_n, SCLK, MOSI, MISO;
   int total = 0;
   int bad = 0;
   logic [15:0] rd;

   always #5 clk = ~clk;

   adc128s_model dut (
      .clk  (clk),
      .rst  (rst),
      .SS_n (SS_n),
      .SCLK (SCLK),
      .MOSI (MOSI),
      .MISO (MISO)
   );

   task automatic clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // SCLK idles high; MISO is sampled just before each rising edge
   task automatic frame(input logic [15:0] mosi_w, input int n_rise, output logic [15:0] miso_w);
      miso_w = 16'h0000;
      SS_n = 1'b0;
      clks(8);
      for (int i = 0; i < n_rise; i++) begin
         SCLK = 1'b0;
         MOSI = (i < 16) ? mosi_w[15 - i] : 1'b1;
         clks(8);
         if (i < 16) miso_w[15 - i] = MISO;
         SCLK = 1'b1;
         clks(8);
      end
      SS_n = 1'b1;
      clks(8);
   endtask

   initial begin
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
      clks(3);
      rst = 1'b0;
      clks(1);
      chk("reset_miso", {15'd0, MISO}, 16'h0000);
      chk("reset_ptr", {13'd0, dut.chan_ptr_q}, 16'h0000);

      frame(16'h0000, 16, rd); chk("first_frame", rd, 16'h0000);
      frame(16'h0800, 16, rd); chk("addr_ch1_a", rd, RAMP ? 16'h0010 : 16'h0000);
      frame(16'h0800, 16, rd); chk("addr_ch1_b", rd, 16'h0800);
      frame(16'h3800, 16, rd); chk("addr_ch7_a", rd, RAMP ? 16'h0810 : 16'h0800);
      chk("ptr_ch7", {13'd0, dut.chan_ptr_q}, 16'h0007);
      frame(16'h2000, 16, rd); chk("read_ch7", rd, 16'h0FFF);
      chk("ptr_ch4", {13'd0, dut.chan_ptr_q}, 16'h0004);
      frame(16'h0000, 18, rd); chk("read_ch4", rd, 16'h0000);
      chk("ptr_after_extra", {13'd0, dut.chan_ptr_q}, 16'h0000);
      chk("miso_idle", {15'd0, MISO}, 16'h0000);

      frame(16'h3800, 16, rd); chk("readdr_ch7", rd, RAMP ? 16'h0020 : 16'h0000);
      frame(16'h0800, 8, rd);
      chk("ptr_after_abort", {13'd0, dut.chan_ptr_q}, 16'h0007);
      frame(16'h3800, 16, rd); chk("read_after_abort", rd, RAMP ? 16'h000F : 16'h0FFF);

      // reset in the middle of a frame after 5 rises
      SS_n = 1'b0;
      clks(8);
      for (int i = 0; i < 5; i++) begin
         SCLK = 1'b0;
         MOSI = (i >= 2) ? 1'b1 : 1'b0;
         clks(8);
         SCLK = 1'b1;
         clks(8);
      end
      rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1;
      clks(3);
      rst = 1'b0;
      clks(8);
      chk("midreset_ptr", {13'd0, dut.chan_ptr_q}, 16'h0000);
      chk("midreset_miso", {15'd0, MISO}, 16'h0000);
      frame(16'h3800, 16, rd); chk("after_midreset", rd, 16'h0000);

      frame(16'h3800, 16, rd); chk("ramp_read1", rd, 16'h0FFF);
      frame(16'h3800, 16, rd); chk("ramp_read2", rd, RAMP ? 16'h000F : 16'h0FFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/adc128s_model.md
# adc128s_model

Behavioral-synthesizable model of an 8-channel, 12-bit SPI analog-to-digital converter (ADC128S-class part). It sits on the board-level bench beside the equalizer and answers that block's SPI reads of the slide-pot channels: the band gains and the volume. Each channel returns a programmable 12-bit value. Conversion results are pipelined one frame, as on the real part.

## Interface
- CH_VAL_0 … CH_VAL_7, 12-bit parameters giving the value each channel returns.
  - Defaults: CH_VAL_1 = 12'h800 (LP gain, unity); CH_VAL_7 = 12'hFFF (volume, max); all others 12'h000.
- RAMP_STEP, default 12'h010. Per-conversion increment, used only when the ramp feature is compiled in.
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  reset, synchronous and active-high.
- SS_n  input  1  active-low frame select from the SPI master.
- SCLK  input  1  SPI serial clock from the master.
  - Idles high; its frequency is at most clk/8.
- MOSI  input  1  command serial data, MSB first.
- MISO  output  1  result serial data, MSB first.

## Operation
- SS_n, SCLK and MOSI each pass through a 2-flop synchronizer into the clk domain. Rise and fall detection of SCLK and SS_n is done on the synchronized values.
- A frame is 16 SCLK rising edges while SS_n is low.
- Frame start is the SS_n falling edge:
  - Bit counter is cleared.
  - 16-bit TX shift register loads {4'b0000, val[chan_ptr]}.
  - MISO presents bit 15 of that word.
- On each SCLK rising edge: shift MOSI into the 16-bit RX register; increment the bit counter.
- On each SCLK falling edge after the first rising edge: shift TX left; MISO shows the new bit 15.
- Frame completes when the 16th rising edge is seen:
  - chan_ptr <= RX[13:11] (address bits). RX bits 15:14 and 10:0 are ignored.
  - The word returned in frame N is therefore the channel addressed in frame N-1.
- SS_n rising before 16 rising edges aborts the frame:
  - RX is discarded.
  - chan_ptr and all channel values are unchanged.
- SCLK edges while SS_n is high are ignored.
- MISO is driven to 0 whenever SS_n (synchronized) is high.
- Channel values: val[n] is initialized from CH_VAL_n at reset and is constant unless the ramp feature is enabled.

## Timing
- Reset values:
  - MISO = 0, chan_ptr = 3'd0, bit counter = 0, TX = 0, RX = 0.
  - val[n] = CH_VAL_n; synchronizer flops = 1 (idle levels).
- Input-to-action latency is 3 clk cycles: 2 synchronizer cycles plus 1 edge-detect register.
- MISO updates 1 clk after the detected SCLK fall or SS_n fall. It is stable well before the master's next SCLK rise, given the clk/8 limit.
- chan_ptr updates in the same clk as the detection of the 16th SCLK rise.
- Reset asserted mid-frame returns every register to its reset value. The master must re-drop SS_n to start a new frame.
- Extra SCLK rises after 16 within one SS_n-low window are ignored; the counter saturates at 16.

## Configuration
- Macro ADC128S_MODEL_RAMP_EN.
- Defined: at each completed frame, val[chan_ptr_old] += RAMP_STEP, modulo 4096. chan_ptr_old is the channel whose result that frame returned. This emulates a pot being moved.
- Undefined: channel values never change after reset.

## Structure
- Package adc128s_pkg:
  - FRAME_BITS = 16, ADDR_MSB = 13, ADDR_LSB = 11.
  - typedef logic [11:0] adc_val_t.
  - typedef enum of the channel roles: B1 = 0, LP = 1, B3 = 2, HP = 3, B2 = 4, VOL = 7.
- One natural sub-module, spi_slave_shift16. It holds the synchronizers, edge detect, bit counter, RX/TX shift registers, done and abort pulses.
- The top adc128s_model holds the channel table, chan_ptr and the ramp logic.

## Test plan
- Reset: hold rst 3 clk, release.
  - MISO = 0 and chan_ptr = 0.
  - The first full frame (MOSI = 16'h0000) returns 16'h0000 on MISO.
- Address ch1: frame with MOSI = 16'h0800, then a frame with MOSI = 16'h0800 → the second frame returns 16'h0800.
- Address ch7: frame with MOSI = 16'h3800, then any frame → 16'h0FFF.
  - Then address ch4 (MOSI = 16'h2000) → the next frame returns 16'h0000.
- Abort: after ch7 is addressed, start a frame with MOSI = 16'h0800 and raise SS_n after 8 SCLK rises.
  - The next full frame still returns 16'h0FFF (chan_ptr unchanged).
- Reset mid-frame: assert rst after 5 SCLK rises while ch7 is addressed → chan_ptr = 0, and the next frame returns 16'h0000.
- With ADC128S_MODEL_RAMP_EN defined: address ch7 and read twice → 16'h0FFF, then 16'h000F (wrap).
  - Without the macro, both reads return 16'h0FFF.
